// File: rtl/fetch_decode_pipeline.sv
// Fetch-to-Decode pipeline register with stall/flush control, a saturating
// total-stall counter and a sticky watchdog for overlong stalls.
module fetch_decode_pipeline #(
  parameter int WIDTH     = 32,
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] InstrF,
  input  logic [WIDTH-1:0] PCPlus4F,
  input  logic             ValidF,
  input  logic             StallD,
  input  logic             FlushD,
  output logic [WIDTH-1:0] InstrD,
  output logic [WIDTH-1:0] PCPlus4D,
  output logic             ValidD,
  output logic [4:0]       RsD,
  output logic [4:0]       RtD,
  output logic [4:0]       RdD,
  output logic [CNT_W-1:0] StallCount,
  output logic             StallTimeout
);

  localparam logic [7:0]       RunMax  = 8'hFF;
  localparam logic [7:0]       RunTrip = 8'(MAX_STALL);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] pc_plus4_q, pc_plus4_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [7:0]       run_cnt_q, run_cnt_d;
  logic             timeout_q, timeout_d;
  logic             stall_cycle;

  // A flush overrides a simultaneous stall, so only unflushed stalls count.
  assign stall_cycle = StallD && !FlushD;

  // NOTE: every output of an always_comb gets a default first so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    instr_d     = instr_q;
    pc_plus4_d  = pc_plus4_q;
    valid_d     = valid_q;
    stall_cnt_d = stall_cnt_q;
    run_cnt_d   = '0;
    timeout_d   = timeout_q;

    if (FlushD) begin
      instr_d    = '0;
      pc_plus4_d = '0;
      valid_d    = 1'b0;
    end else if (StallD) begin
      if (stall_cnt_q != CntMax) stall_cnt_d = stall_cnt_q + 1'b1;
      run_cnt_d = (run_cnt_q != RunMax) ? run_cnt_q + 8'd1 : RunMax;
    end else begin
      instr_d    = InstrF;
      pc_plus4_d = PCPlus4F;
      valid_d    = ValidF;
    end

    // The run counter's next value reaching the limit trips the watchdog on
    // the same edge, making it visible after exactly MAX_STALL stall cycles.
    if (stall_cycle && run_cnt_d == RunTrip) timeout_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q     <= '0;
      pc_plus4_q  <= '0;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
      run_cnt_q   <= '0;
      timeout_q   <= 1'b0;
    end else begin
      instr_q     <= instr_d;
      pc_plus4_q  <= pc_plus4_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      run_cnt_q   <= run_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign InstrD       = instr_q;
  assign PCPlus4D     = pc_plus4_q;
  assign ValidD       = valid_q;
  assign RsD          = instr_q[25:21];
  assign RtD          = instr_q[20:16];
  assign RdD          = instr_q[15:11];
  assign StallCount   = stall_cnt_q;
  assign StallTimeout = timeout_q;

endmodule

// File: tb/tb_fetch_decode_pipeline.sv
// Directed bench for fetch_decode_pipeline: a default instance plus a
// CNT_W=4 instance sharing the same stimulus to exercise counter saturation.
module tb_fetch_decode_pipeline;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrF, PCPlus4F;
  logic        ValidF, StallD, FlushD;

  logic [31:0] InstrD, PCPlus4D;
  logic        ValidD, StallTimeout;
  logic [4:0]  RsD, RtD, RdD;
  logic [15:0] StallCount;

  logic [31:0] s_InstrD, s_PCPlus4D;
  logic        s_ValidD, s_StallTimeout;
  logic [4:0]  s_RsD, s_RtD, s_RdD;
  logic [3:0]  s_StallCount;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_decode_pipeline #(.WIDTH(32), .CNT_W(16), .MAX_STALL(8)) dut (
    .clk(clk), .rst(rst), .InstrF(InstrF), .PCPlus4F(PCPlus4F), .ValidF(ValidF),
    .StallD(StallD), .FlushD(FlushD), .InstrD(InstrD), .PCPlus4D(PCPlus4D),
    .ValidD(ValidD), .RsD(RsD), .RtD(RtD), .RdD(RdD),
    .StallCount(StallCount), .StallTimeout(StallTimeout)
  );

  fetch_decode_pipeline #(.WIDTH(32), .CNT_W(4), .MAX_STALL(8)) dut_sat (
    .clk(clk), .rst(rst), .InstrF(InstrF), .PCPlus4F(PCPlus4F), .ValidF(ValidF),
    .StallD(StallD), .FlushD(FlushD), .InstrD(s_InstrD), .PCPlus4D(s_PCPlus4D),
    .ValidD(s_ValidD), .RsD(s_RsD), .RtD(s_RtD), .RdD(s_RdD),
    .StallCount(s_StallCount), .StallTimeout(s_StallTimeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic v);
    InstrF   = instr;
    PCPlus4F = pc;
    ValidF   = v;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst = 1'b1; StallD = 1'b0; FlushD = 1'b0;
    drive(32'h0, 32'h0, 1'b0);

    // Reset state
    tick(2);
    check("rst_instr", InstrD, 32'h0);
    check("rst_pc", PCPlus4D, 32'h0);
    check("rst_valid", {31'b0, ValidD}, 32'h0);
    check("rst_cnt", {16'b0, StallCount}, 32'h0);
    check("rst_timeout", {31'b0, StallTimeout}, 32'h0);

    // Reset then load: one-cycle latency, register fields decoded
    rst = 1'b0;
    drive(32'h8C220004, 32'h00000008, 1'b1);
    tick();
    check("load_instr", InstrD, 32'h8C220004);
    check("load_pc", PCPlus4D, 32'h00000008);
    check("load_valid", {31'b0, ValidD}, 32'h1);
    check("load_rs", {27'b0, RsD}, 32'd1);
    check("load_rt", {27'b0, RtD}, 32'd2);
    check("load_rd", {27'b0, RdD}, 32'd0);

    drive(32'h00851020, 32'h0000000C, 1'b1);
    tick();
    check("load2_instr", InstrD, 32'h00851020);
    check("load2_rs", {27'b0, RsD}, 32'd4);
    check("load2_rt", {27'b0, RtD}, 32'd5);
    check("load2_rd", {27'b0, RdD}, 32'd2);

    // Stall hold for 3 cycles with changing Fetch inputs
    StallD = 1'b1;
    drive(32'hFFFFFFFF, 32'h00000010, 1'b1);
    tick(3);
    check("stall_instr", InstrD, 32'h00851020);
    check("stall_pc", PCPlus4D, 32'h0000000C);
    check("stall_rd", {27'b0, RdD}, 32'd2);
    check("stall_cnt3", {16'b0, StallCount}, 32'd3);
    check("stall_timeout", {31'b0, StallTimeout}, 32'h0);

    // Release: next Fetch value loads in one cycle
    StallD = 1'b0;
    drive(32'h12345678, 32'h00000010, 1'b1);
    tick();
    check("release_instr", InstrD, 32'h12345678);
    check("release_cnt", {16'b0, StallCount}, 32'd3);

    // ValidF=0 still loads data, ValidD goes low
    drive(32'hAAAA5555, 32'h00000014, 1'b0);
    tick();
    check("inval_instr", InstrD, 32'hAAAA5555);
    check("inval_pc", PCPlus4D, 32'h00000014);
    check("inval_valid", {31'b0, ValidD}, 32'h0);

    // Two stalls, then flush with stall asserted
    drive(32'h11111111, 32'h00000018, 1'b1);
    StallD = 1'b1;
    tick(2);
    check("pre_flush_cnt", {16'b0, StallCount}, 32'd5);
    FlushD = 1'b1;
    tick();
    check("flush_instr", InstrD, 32'h0);
    check("flush_pc", PCPlus4D, 32'h0);
    check("flush_valid", {31'b0, ValidD}, 32'h0);
    check("flush_rs", {27'b0, RsD}, 32'd0);
    check("flush_cnt", {16'b0, StallCount}, 32'd5);
    FlushD = 1'b0;

    // 7 stalls after the flush: run restarts at 0, so no timeout
    tick(7);
    check("run7_cnt", {16'b0, StallCount}, 32'd12);
    check("run7_timeout", {31'b0, StallTimeout}, 32'h0);
    check("sat_cnt12", {28'b0, s_StallCount}, 32'd12);

    StallD = 1'b0;
    drive(32'h22222222, 32'h0000001C, 1'b1);
    tick();
    check("gap_instr", InstrD, 32'h22222222);
    check("gap_timeout", {31'b0, StallTimeout}, 32'h0);

    // 8 consecutive stalls: timeout visible exactly after the 8th
    StallD = 1'b1;
    tick(7);
    check("run8_at7_timeout", {31'b0, StallTimeout}, 32'h0);
    tick();
    check("run8_timeout", {31'b0, StallTimeout}, 32'h1);
    check("run8_cnt", {16'b0, StallCount}, 32'd20);
    check("run8_instr", InstrD, 32'h22222222);

    StallD = 1'b0;
    tick();
    check("sticky_timeout", {31'b0, StallTimeout}, 32'h1);
    check("sticky_cnt", {16'b0, StallCount}, 32'd20);
    check("sat_cnt_early", {28'b0, s_StallCount}, 32'd15);

    // Saturation on the narrow counter after a fresh reset
    rst = 1'b1;
    tick();
    check("rst2_cnt", {16'b0, StallCount}, 32'd0);
    check("rst2_sat_cnt", {28'b0, s_StallCount}, 32'd0);
    rst = 1'b0;
    StallD = 1'b1;
    tick(15);
    check("sat15", {28'b0, s_StallCount}, 32'd15);
    tick(5);
    check("sat20", {28'b0, s_StallCount}, 32'd15);
    check("wide20", {16'b0, StallCount}, 32'd20);
    check("sat_timeout", {31'b0, StallTimeout}, 32'h1);

    // Reset in the middle of a stall
    rst = 1'b1;
    tick();
    check("midrst_instr", InstrD, 32'h0);
    check("midrst_pc", PCPlus4D, 32'h0);
    check("midrst_valid", {31'b0, ValidD}, 32'h0);
    check("midrst_cnt", {16'b0, StallCount}, 32'd0);
    check("midrst_timeout", {31'b0, StallTimeout}, 32'h0);
    check("midrst_sat_cnt", {28'b0, s_StallCount}, 32'd0);

    rst = 1'b0;
    StallD = 1'b0;
    drive(32'h01234567, 32'h00000040, 1'b1);
    tick();
    check("resume_instr", InstrD, 32'h01234567);
    check("resume_pc", PCPlus4D, 32'h00000040);
    check("resume_valid", {31'b0, ValidD}, 32'h1);
    check("resume_cnt", {16'b0, StallCount}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
